// File: rtl/rr_multi_selector.sv
// rtl/rr_multi_selector.sv - registered rotating-priority multi-grant selector (optional PSEL_PRIO_OVERRIDE_EN adds prio port)
module rr_multi_selector #(
    parameter int WIDTH = 16,
    parameter int REQS  = 2,
    parameter int PTR_W = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        req,
    input  logic                    stall,
`ifdef PSEL_PRIO_OVERRIDE_EN
    input  logic [WIDTH-1:0]        prio,
`endif
    output logic [WIDTH*REQS-1:0]   gnt_bus,
    output logic [WIDTH-1:0]        gnt,
    output logic [REQS-1:0]         gnt_valid,
    output logic [PTR_W-1:0]        ptr,
    output logic                    empty
);

    localparam logic [PTR_W:0] WIDTH_X = (PTR_W+1)'(WIDTH);

    logic [REQS-1:0][WIDTH-1:0] gnt_slots;
    logic [REQS-1:0][WIDTH-1:0] sel;
    logic [REQS-1:0]            sel_valid;
    logic [WIDTH-1:0]           elig;
    logic [WIDTH-1:0]           pri;
    logic [WIDTH-1:0]           cand;
    logic [PTR_W:0]             sum;
    logic [PTR_W-1:0]           idx;
    logic [PTR_W-1:0]           last_idx;
    logic [PTR_W:0]             nxt_sum;
    logic [PTR_W-1:0]           ptr_next;
    int                         cnt;

`ifdef PSEL_PRIO_OVERRIDE_EN
    assign pri = prio;
`else
    // All requesters count as high priority, so the second pass never fills anything.
    assign pri = '1;
`endif

    assign empty   = ~|req;
    assign elig    = req & ~gnt;
    assign gnt_bus = gnt_slots;

    always_comb begin
        gnt = '0;
        for (int k = 0; k < REQS; k++) begin
            gnt = gnt | gnt_slots[k];
        end
    end

    // Two passes in search order: priority-qualified requesters first, then the rest.
    always_comb begin
        sel       = '0;
        sel_valid = '0;
        last_idx  = '0;
        cand      = '0;
        sum       = '0;
        idx       = '0;
        cnt       = 0;
        for (int pass = 0; pass < 2; pass++) begin
            cand = (pass == 0) ? (elig & pri) : (elig & ~pri);
            for (int j = 0; j < WIDTH; j++) begin
                sum = {1'b0, ptr} + (PTR_W+1)'(j);
                if (sum >= WIDTH_X) begin
                    sum = sum - WIDTH_X;
                end
                idx = sum[PTR_W-1:0];
                if (cand[idx]) begin
                    for (int k = 0; k < REQS; k++) begin
                        if (cnt == k) begin
                            sel[k][idx]  = 1'b1;
                            sel_valid[k] = 1'b1;
                            last_idx     = idx;
                        end
                    end
                    if (cnt < REQS) begin
                        cnt = cnt + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        nxt_sum  = {1'b0, last_idx} + {{PTR_W{1'b0}}, 1'b1};
        ptr_next = (nxt_sum == WIDTH_X) ? '0 : nxt_sum[PTR_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_slots <= '0;
            gnt_valid <= '0;
            ptr       <= '0;
        end else if (!stall) begin
            gnt_slots <= sel;
            gnt_valid <= sel_valid;
            if (|sel_valid) begin
                ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_rr_multi_selector.sv
// tb/tb_rr_multi_selector.sv - directed table-driven bench for rr_multi_selector (WIDTH=8, REQS=2)
module tb_rr_multi_selector;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  req;
    logic        stall;
    logic [7:0]  prio;
    logic [15:0] gnt_bus;
    logic [7:0]  gnt;
    logic [1:0]  gnt_valid;
    logic [2:0]  ptr;
    logic        empty;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rr_multi_selector #(.WIDTH(8), .REQS(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .stall     (stall),
`ifdef PSEL_PRIO_OVERRIDE_EN
        .prio      (prio),
`endif
        .gnt_bus   (gnt_bus),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .ptr       (ptr),
        .empty     (empty)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [7:0]  rq;
        logic [7:0]  pr;
        logic [15:0] bus;
        logic [1:0]  vld;
        logic [2:0]  p;
        logic        emp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic stl, input logic [7:0] rq,
                        input logic [7:0] pr, input logic [15:0] bus, input logic [1:0] vld,
                        input logic [2:0] p, input logic emp);
        reset = rst;
        stall = stl;
        req   = rq;
        prio  = pr;
        #1;
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, emp});
        @(posedge clock);
        #1;
        check({tag, ".gnt_bus"}, {16'd0, gnt_bus}, {16'd0, bus});
        check({tag, ".gnt"}, {24'd0, gnt}, {24'd0, bus[15:8] | bus[7:0]});
        check({tag, ".gnt_valid"}, {30'd0, gnt_valid}, {30'd0, vld});
        check({tag, ".ptr"}, {29'd0, ptr}, {29'd0, p});
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        req   = 8'h00;
        prio  = 8'h00;

        // {reset, stall, req, prio, {slot1,slot0}, gnt_valid, ptr, empty}
        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 16'h0000, 2'b00, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 16'h0000, 2'b00, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 16'h0201, 2'b11, 3'd2, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 16'h0804, 2'b11, 3'd4, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'hF0, 8'h00, 16'h0804, 2'b11, 3'd4, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hF0, 8'h00, 16'h0804, 2'b11, 3'd4, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'hF0, 8'h00, 16'h0804, 2'b11, 3'd4, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'hF0, 8'h00, 16'h2010, 2'b11, 3'd6, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h41, 8'h00, 16'h0140, 2'b11, 3'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h10, 8'h00, 16'h0000, 2'b00, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h10, 8'h00, 16'h0010, 2'b01, 3'd5, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h10, 8'h00, 16'h0000, 2'b00, 3'd5, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h10, 8'h00, 16'h0010, 2'b01, 3'd5, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h10, 8'h00, 16'h0000, 2'b00, 3'd5, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 2'b00, 3'd5, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'h03, 8'h00, 16'h0201, 2'b11, 3'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'h0C, 8'h00, 16'h0201, 2'b11, 3'd2, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 8'hFF, 8'h00, 16'h0000, 2'b00, 3'd0, 1'b0};

        @(posedge clock);
        #1;
        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].stl, vecs[i].rq, vecs[i].pr,
                 vecs[i].bus, vecs[i].vld, vecs[i].p, vecs[i].emp);
        end

        // Stall release must mask against the held grant, not a fresh one.
        step("hold.rst",  1'b1, 1'b0, 8'h01, 8'h00, 16'h0000, 2'b00, 3'd0, 1'b0);
        step("hold.g",    1'b0, 1'b0, 8'h01, 8'h00, 16'h0001, 2'b01, 3'd1, 1'b0);
        step("hold.s1",   1'b0, 1'b1, 8'h01, 8'h00, 16'h0001, 2'b01, 3'd1, 1'b0);
        step("hold.s2",   1'b0, 1'b1, 8'h01, 8'h00, 16'h0001, 2'b01, 3'd1, 1'b0);
        step("hold.rel",  1'b0, 1'b0, 8'h01, 8'h00, 16'h0000, 2'b00, 3'd1, 1'b0);
        step("hold.next", 1'b0, 1'b0, 8'h01, 8'h00, 16'h0001, 2'b01, 3'd1, 1'b0);

        // Priority qualifier: with the override, index 7 jumps ahead of the rotation.
        step("prio.rst",  1'b1, 1'b0, 8'hFF, 8'h80, 16'h0000, 2'b00, 3'd0, 1'b0);
`ifdef PSEL_PRIO_OVERRIDE_EN
        step("prio.sel",  1'b0, 1'b0, 8'hFF, 8'h80, 16'h0180, 2'b11, 3'd1, 1'b0);
`else
        step("prio.sel",  1'b0, 1'b0, 8'hFF, 8'h80, 16'h0201, 2'b11, 3'd2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
